mem_access_unit: RTL and testbench

//  Load/store executor that consumes the decoder's memory controls (mem_read/mem_write/width/zero_extend)

---
 rtl/mem_access_unit_if.sv | 37 +++
 rtl/mem_access_unit.sv | 147 ++++++++++++++
 tb/tb_mem_access_unit.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Pipeline-side memory controls and word-wide data bus of the MEM-stage load/store unit.
// master = the load/store unit; slave = the pipeline/bus environment driving it.
interface mem_access_unit_if;
  logic        valid_in;
  logic        mem_read_in;
  logic        mem_write_in;
  logic [3:0]  mem_width_in;
  logic        mem_zero_extend_in;
  logic [31:0] addr_in;
  logic [31:0] wdata_in;
  logic [31:0] bus_addr_out;
  logic [31:0] bus_wdata_out;
  logic [3:0]  bus_strb_out;
  logic        bus_read_out;
  logic        bus_write_out;
  logic        bus_ready_in;
  logic [31:0] bus_rdata_in;
  logic        stall_out;
  logic [31:0] rdata_out;
  logic        rdata_valid_out;
  logic        misaligned_out;
  logic        fault_out;

  modport master (
    input  valid_in, mem_read_in, mem_write_in, mem_width_in, mem_zero_extend_in,
    input  addr_in, wdata_in, bus_ready_in, bus_rdata_in,
    output bus_addr_out, bus_wdata_out, bus_strb_out, bus_read_out, bus_write_out,
    output stall_out, rdata_out, rdata_valid_out, misaligned_out, fault_out
  );

  modport slave (
    output valid_in, mem_read_in, mem_write_in, mem_width_in, mem_zero_extend_in,
    output addr_in, wdata_in, bus_ready_in, bus_rdata_in,
    input  bus_addr_out, bus_wdata_out, bus_strb_out, bus_read_out, bus_write_out,
    input  stall_out, rdata_out, rdata_valid_out, misaligned_out, fault_out
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store executor: one bus access per instruction, min 2 cycles start->result pulse.
// Stalls the pipeline while starting and while the bus holds off ready; aborts after TIMEOUT_CYCLES.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic           clk,
  input logic           reset,
  mem_access_unit_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_DONE, S_ERR, S_ABORT} state_t;
  typedef enum logic [1:0] {W_WORD, W_HALF, W_BYTE} width_t;

  state_t      r_state, w_next;
  width_t      r_width, w_width;
  logic [1:0]  r_addr_lo;
  logic        r_zext;
  logic        r_store;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wdata;
  logic [3:0]  r_bus_strb;
  logic [31:0] r_cnt;
  logic [31:0] r_rdata;

  logic        w_start;
  logic        w_misaligned;
  logic        w_timeout;
  logic [31:0] w_st_wdata;
  logic [3:0]  w_st_strb;
  logic [31:0] w_ld_data;
  logic [15:0] w_ld_half;
  logic [7:0]  w_ld_byte;

  assign w_start = bus.valid_in & (bus.mem_read_in | bus.mem_write_in);

  always_comb begin
    case (bus.mem_width_in)
      4'b0101: w_width = W_HALF;
      4'b1010: w_width = W_BYTE;
      default: w_width = W_WORD;
    endcase
  end

  assign w_misaligned = ((w_width == W_HALF) && bus.addr_in[0]) ||
                        ((w_width == W_WORD) && (bus.addr_in[1:0] != 2'b00));

  always_comb begin
    w_st_wdata = bus.wdata_in;
    w_st_strb  = 4'b1111;
    case (w_width)
      W_BYTE: begin
        w_st_wdata = {4{bus.wdata_in[7:0]}};
        w_st_strb  = 4'b0001 << bus.addr_in[1:0];
      end
      W_HALF: begin
        w_st_wdata = {2{bus.wdata_in[15:0]}};
        w_st_strb  = bus.addr_in[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w_st_wdata = bus.wdata_in;
        w_st_strb  = 4'b1111;
      end
    endcase
  end

  // Lane selection uses the offset captured at start, not the live address.
  assign w_ld_half = r_addr_lo[1] ? bus.bus_rdata_in[31:16] : bus.bus_rdata_in[15:0];
  always_comb begin
    case (r_addr_lo)
      2'd1:    w_ld_byte = bus.bus_rdata_in[15:8];
      2'd2:    w_ld_byte = bus.bus_rdata_in[23:16];
      2'd3:    w_ld_byte = bus.bus_rdata_in[31:24];
      default: w_ld_byte = bus.bus_rdata_in[7:0];
    endcase
  end

  always_comb begin
    case (r_width)
      W_BYTE:  w_ld_data = {{24{~r_zext & w_ld_byte[7]}}, w_ld_byte};
      W_HALF:  w_ld_data = {{16{~r_zext & w_ld_half[15]}}, w_ld_half};
      default: w_ld_data = bus.bus_rdata_in;
    endcase
  end

  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == TIMEOUT_CYCLES - 1);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_next = w_misaligned ? S_ERR : S_REQ;
      end
      S_REQ: begin
        if (bus.bus_ready_in)  w_next = S_DONE;
        else if (w_timeout)    w_next = S_ABORT;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_width     <= W_WORD;
      r_addr_lo   <= 2'b00;
      r_zext      <= 1'b0;
      r_store     <= 1'b0;
      r_bus_addr  <= 32'd0;
      r_bus_wdata <= 32'd0;
      r_bus_strb  <= 4'b0000;
      r_cnt       <= 32'd0;
      r_rdata     <= 32'd0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && w_start) begin
        r_width     <= w_width;
        r_addr_lo   <= bus.addr_in[1:0];
        r_zext      <= bus.mem_zero_extend_in;
        r_store     <= bus.mem_write_in;
        r_bus_addr  <= {bus.addr_in[31:2], 2'b00};
        r_bus_wdata <= w_st_wdata;
        r_bus_strb  <= bus.mem_write_in ? w_st_strb : 4'b0000;
      end
      if (r_state != S_REQ) begin
        r_cnt <= 32'd0;
      end else if (!bus.bus_ready_in) begin
        r_cnt <= r_cnt + 32'd1;
      end
      if (r_state == S_REQ) begin
        if (bus.bus_ready_in && !r_store) r_rdata <= w_ld_data;
        else if (!bus.bus_ready_in && w_timeout) r_rdata <= 32'd0;
      end
    end
  end

  assign bus.bus_addr_out    = r_bus_addr;
  assign bus.bus_wdata_out   = r_bus_wdata;
  assign bus.bus_strb_out    = r_bus_strb;
  assign bus.bus_read_out    = (r_state == S_REQ) & ~r_store;
  assign bus.bus_write_out   = (r_state == S_REQ) & r_store;
  assign bus.stall_out       = ((r_state == S_IDLE) & w_start) | (r_state == S_REQ);
  assign bus.rdata_out       = r_rdata;
  assign bus.rdata_valid_out = (r_state == S_DONE);
  assign bus.misaligned_out  = (r_state == S_ERR);
  assign bus.fault_out       = (r_state == S_ABORT);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table of single accesses plus timeout and reset sequences.
module tb_mem_access_unit;

  logic clk;
  logic reset;
  mem_access_unit_if u_if ();

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [3:0]  width;
    logic        zext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic        mis;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_strb;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    u_if.valid_in           = 1'b0;
    u_if.mem_read_in        = 1'b0;
    u_if.mem_write_in       = 1'b0;
    u_if.mem_width_in       = 4'b0000;
    u_if.mem_zero_extend_in = 1'b0;
    u_if.addr_in            = 32'd0;
    u_if.wdata_in           = 32'd0;
    u_if.bus_ready_in       = 1'b0;
    u_if.bus_rdata_in       = 32'd0;
  endtask

  task automatic drive_start(input vec_t v);
    @(negedge clk);
    u_if.valid_in           = 1'b1;
    u_if.mem_read_in        = v.rd;
    u_if.mem_write_in       = v.wr;
    u_if.mem_width_in       = v.width;
    u_if.mem_zero_extend_in = v.zext;
    u_if.addr_in            = v.addr;
    u_if.wdata_in           = v.wdata;
    u_if.bus_rdata_in       = v.rdata;
    u_if.bus_ready_in       = 1'b0;
    #1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    drive_start(v);
    chk($sformatf("v%0d.stall_start", idx), {31'd0, u_if.stall_out}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    u_if.valid_in = 1'b0;
    if (v.mis) begin
      #1;
      chk($sformatf("v%0d.misaligned", idx), {31'd0, u_if.misaligned_out}, 32'd1);
      chk($sformatf("v%0d.no_bus", idx), {30'd0, u_if.bus_read_out, u_if.bus_write_out}, 32'd0);
      chk($sformatf("v%0d.stall_err", idx), {31'd0, u_if.stall_out}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk($sformatf("v%0d.mis_pulse_end", idx), {31'd0, u_if.misaligned_out}, 32'd0);
      return;
    end
    for (int w = 0; w <= v.waits; w++) begin
      if (w > 0) @(negedge clk);
      u_if.bus_ready_in = (w == v.waits);
      #1;
      chk($sformatf("v%0d.strobes_c%0d", idx, w), {30'd0, u_if.bus_read_out, u_if.bus_write_out},
          {30'd0, ~v.wr, v.wr});
      chk($sformatf("v%0d.stall_req_c%0d", idx, w), {31'd0, u_if.stall_out}, 32'd1);
      chk($sformatf("v%0d.no_pulse_c%0d", idx, w), {31'd0, u_if.rdata_valid_out}, 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    u_if.bus_ready_in = 1'b0;
    #1;
    chk($sformatf("v%0d.bus_addr", idx), u_if.bus_addr_out, v.e_addr);
    chk($sformatf("v%0d.bus_wdata", idx), u_if.bus_wdata_out, v.e_wdata);
    chk($sformatf("v%0d.bus_strb", idx), {28'd0, u_if.bus_strb_out}, {28'd0, v.e_strb});
    chk($sformatf("v%0d.rdata_valid", idx), {31'd0, u_if.rdata_valid_out}, 32'd1);
    chk($sformatf("v%0d.stall_done", idx), {31'd0, u_if.stall_out}, 32'd0);
    chk($sformatf("v%0d.strobes_done", idx), {30'd0, u_if.bus_read_out, u_if.bus_write_out}, 32'd0);
    if (!v.wr) chk($sformatf("v%0d.rdata", idx), u_if.rdata_out, v.e_rdata);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk($sformatf("v%0d.pulse_end", idx), {31'd0, u_if.rdata_valid_out}, 32'd0);
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [3:0] width,
                              input logic zext, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int waits, input logic mis,
                              input logic [31:0] e_addr, input logic [31:0] e_wdata,
                              input logic [3:0] e_strb, input logic [31:0] e_rdata);
    vec_t v;
    v.rd = rd; v.wr = wr; v.width = width; v.zext = zext; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.waits = waits; v.mis = mis; v.e_addr = e_addr; v.e_wdata = e_wdata;
    v.e_strb = e_strb; v.e_rdata = e_rdata;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t lw_to;
    // rd wr width zext addr wdata rdata waits mis | e_addr e_wdata e_strb e_rdata
    tbl.push_back(mk(1, 0, 4'b1010, 0, 32'h0000_1003, 32'h0, 32'h80FF_0000, 0, 0,
                     32'h0000_1000, 32'h0, 4'b0000, 32'hFFFF_FF80));
    tbl.push_back(mk(1, 0, 4'b0101, 1, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 3, 0,
                     32'h0000_2000, 32'h0, 4'b0000, 32'h0000_BEEF));
    tbl.push_back(mk(0, 1, 4'b1010, 0, 32'h0000_0011, 32'hAABB_CCDD, 32'h0, 2, 0,
                     32'h0000_0010, 32'hDDDD_DDDD, 4'b0010, 32'h0));
    tbl.push_back(mk(1, 0, 4'b0000, 0, 32'h0000_0006, 32'h0, 32'h1111_1111, 0, 1,
                     32'h0, 32'h0, 4'b0000, 32'h0));
    tbl.push_back(mk(0, 1, 4'b0101, 0, 32'h0000_0102, 32'h1234_5678, 32'h0, 1, 0,
                     32'h0000_0100, 32'h5678_5678, 4'b1100, 32'h0));
    tbl.push_back(mk(0, 1, 4'b0000, 0, 32'h0000_0200, 32'hCAFE_F00D, 32'h0, 0, 0,
                     32'h0000_0200, 32'hCAFE_F00D, 4'b1111, 32'h0));
    tbl.push_back(mk(1, 0, 4'b0101, 0, 32'h0000_0300, 32'h0, 32'h1234_8001, 0, 0,
                     32'h0000_0300, 32'h0, 4'b0000, 32'hFFFF_8001));
    tbl.push_back(mk(1, 0, 4'b1010, 1, 32'h0000_0401, 32'h0, 32'h0000_A500, 1, 0,
                     32'h0000_0400, 32'h0, 4'b0000, 32'h0000_00A5));
    tbl.push_back(mk(0, 1, 4'b0101, 0, 32'h0000_0003, 32'h0000_FFFF, 32'h0, 0, 1,
                     32'h0, 32'h0, 4'b0000, 32'h0));
    tbl.push_back(mk(1, 0, 4'b1010, 0, 32'h0000_0502, 32'h0, 32'h007F_0000, 0, 0,
                     32'h0000_0500, 32'h0, 4'b0000, 32'h0000_007F));
    tbl.push_back(mk(1, 0, 4'b1111, 0, 32'h0000_0600, 32'h0, 32'hDEAD_BEEF, 2, 0,
                     32'h0000_0600, 32'h0, 4'b0000, 32'hDEAD_BEEF));
    tbl.push_back(mk(1, 1, 4'b1010, 0, 32'h0000_0700, 32'h0000_0011, 32'h0, 0, 0,
                     32'h0000_0700, 32'h1111_1111, 4'b0001, 32'h0));
    tbl.push_back(mk(1, 0, 4'b0000, 1, 32'h0000_0800, 32'h0, 32'h8000_0000, 1, 0,
                     32'h0000_0800, 32'h0, 4'b0000, 32'h8000_0000));

    idle_inputs();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset.bus_addr", u_if.bus_addr_out, 32'd0);
    chk("reset.bus_wdata", u_if.bus_wdata_out, 32'd0);
    chk("reset.strb", {28'd0, u_if.bus_strb_out}, 32'd0);
    chk("reset.rdata", u_if.rdata_out, 32'd0);
    chk("reset.flags", {26'd0, u_if.bus_read_out, u_if.bus_write_out, u_if.stall_out,
        u_if.rdata_valid_out, u_if.misaligned_out, u_if.fault_out}, 32'd0);

    foreach (tbl[i]) run_vec(i, tbl[i]);

    // Timeout: no ready for 4 REQ cycles -> fault pulse, rdata cleared.
    lw_to = mk(1, 0, 4'b0000, 0, 32'h0000_0900, 32'h0, 32'h5555_5555, 0, 0,
               32'h0000_0900, 32'h0, 4'b0000, 32'h0);
    drive_start(lw_to);
    @(posedge clk);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      u_if.valid_in = 1'b0;
      #1;
      chk($sformatf("to.read_c%0d", c), {31'd0, u_if.bus_read_out}, 32'd1);
      chk($sformatf("to.nofault_c%0d", c), {31'd0, u_if.fault_out}, 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    #1;
    chk("to.fault", {31'd0, u_if.fault_out}, 32'd1);
    chk("to.rdata_zero", u_if.rdata_out, 32'd0);
    chk("to.stall", {30'd0, u_if.stall_out, u_if.bus_read_out}, 32'd0);
    chk("to.no_valid", {31'd0, u_if.rdata_valid_out}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("to.fault_end", {31'd0, u_if.fault_out}, 32'd0);

    // Counter must restart after an abort: 3 wait states complete normally.
    run_vec(100, tbl[1]);

    // Reset during the second REQ cycle drops the access.
    drive_start(lw_to);
    @(posedge clk);
    @(negedge clk);
    u_if.valid_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst.read_before", {31'd0, u_if.bus_read_out}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst.bus_addr", u_if.bus_addr_out, 32'd0);
    chk("rst.rdata", u_if.rdata_out, 32'd0);
    chk("rst.flags", {22'd0, u_if.bus_strb_out, u_if.bus_read_out, u_if.bus_write_out,
        u_if.stall_out, u_if.rdata_valid_out, u_if.misaligned_out, u_if.fault_out}, 32'd0);
    reset = 1'b0;
    u_if.bus_ready_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    u_if.bus_ready_in = 1'b0;
    #1;
    chk("rst.late_ready_c0", {30'd0, u_if.rdata_valid_out, u_if.bus_read_out}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst.late_ready_c1", {31'd0, u_if.rdata_valid_out}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
